// File: rtl/key_debounce.sv
// Synchronises one raw active-low key and debounces it with a saturating
// low-level counter; press_evt fires for exactly one cycle per accepted press.
module key_debounce #(
    parameter int                   CNT_WIDTH = 20,
    parameter logic [CNT_WIDTH-1:0] CNT_MAX   = 20'd999_999
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_in,
    output logic press_evt
);

    localparam logic [CNT_WIDTH-1:0] CNT_EVT = CNT_MAX - 1'b1;

    logic                 key_s1;
    logic                 key_s2;
    logic [CNT_WIDTH-1:0] cnt;

    // Released level on reset so no phantom press is seen after reset.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            key_s1 <= 1'b1;
            key_s2 <= 1'b1;
        end else begin
            key_s1 <= key_in;
            key_s2 <= key_s1;
        end
    end

    // Saturating at CNT_MAX keeps a held key from ever repeating.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt <= '0;
        end else if (key_s2) begin
            cnt <= '0;
        end else if (cnt < CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign press_evt = !key_s2 && (cnt == CNT_EVT);

endmodule

// File: rtl/coin_input_conditioner.sv
// Debounces both coin keys and issues one single-cycle, mutually exclusive
// pulse per accepted coin, queueing a coincident pair with 1-yuan first.
module coin_input_conditioner #(
    parameter int                   CNT_WIDTH = 20,
    parameter logic [CNT_WIDTH-1:0] CNT_MAX   = 20'd999_999
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_one,
    input  logic key_half,
    output logic po_money_one,
    output logic po_money_half
);

    logic evt_one;
    logic evt_half;
    logic pend_one;
    logic pend_half;
    logic issue_one;
    logic issue_half;

    key_debounce #(
        .CNT_WIDTH (CNT_WIDTH),
        .CNT_MAX   (CNT_MAX)
    ) u_deb_one (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_in    (key_one),
        .press_evt (evt_one)
    );

    key_debounce #(
        .CNT_WIDTH (CNT_WIDTH),
        .CNT_MAX   (CNT_MAX)
    ) u_deb_half (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .key_in    (key_half),
        .press_evt (evt_half)
    );

    assign issue_one  = pend_one;
    assign issue_half = pend_half && !pend_one;

    // A new event wins over the clear of the same flag.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pend_one      <= 1'b0;
            pend_half     <= 1'b0;
            po_money_one  <= 1'b0;
            po_money_half <= 1'b0;
        end else begin
            pend_one      <= evt_one  || (pend_one  && !issue_one);
            pend_half     <= evt_half || (pend_half && !issue_half);
            po_money_one  <= issue_one;
            po_money_half <= issue_half;
        end
    end

endmodule
